// File: rtl/imem_fetch_arbiter.sv
// Fetch-stage controller: owns the PC, arbitrates the single imem read port
// between the fetch path and a debug requester, and drives the IF/ID outputs.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mem_addr_o / mem_instr_i     combinational-read instruction memory port
//   stall_i                      hazard stall (holds PC and IF/ID outputs)
//   redirect_i, redirect_pc_i    taken branch/jump and its target
//   dbg_req_i, dbg_addr_i        debug read request (held until granted)
//   dbg_gnt_o                    port owned by debug this cycle
//   dbg_valid_o, dbg_data_o      registered debug read result (1-cycle pulse)
//   pc_o, pc_plus4_o, instr_o    IF/ID instruction bundle
//   instr_valid_o                0 marks a bubble
//   addr_err_o                   sticky misaligned/out-of-range fetch flag
module imem_fetch_arbiter #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned MEM_WORDS      = 32,
    parameter int unsigned DBG_STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_addr_i,
    output logic        dbg_gnt_o,
    output logic        dbg_valid_o,
    output logic [31:0] dbg_data_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        addr_err_o
);

    localparam int unsigned SW =
        (DBG_STARVE_MAX > 0) ? $clog2(DBG_STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(DBG_STARVE_MAX);
    localparam logic [32:0]   MEM_BYTES  = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [31:0]   pco_q, pco_d;
    logic [31:0]   pcp4_q, pcp4_d;
    logic          err_q, err_d;
    logic          dvalid_q, dvalid_d;
    logic [31:0]   ddata_q, ddata_d;
    logic [SW-1:0] starve_q, starve_d;

    logic gnt;
    logic fetch_en;
    logic bubble;
    logic fault;

    // Control FSM plus port arbitration. The port is free for debug whenever
    // the pipeline is not consuming it (IDLE/HOLD) or a redirect throws the
    // fetch away anyway; otherwise debug waits until it has starved.
    always_comb begin
        state_d  = state_q;
        gnt      = 1'b0;
        fetch_en = 1'b0;
        bubble   = 1'b0;

        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (stall_i && !redirect_i) state_d = S_HOLD;
            S_HOLD:  if (!stall_i || redirect_i) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        gnt = dbg_req_i &&
              ((state_q != S_FETCH) || redirect_i ||
               (starve_q == STARVE_MAX));

        // HOLD with stall released fetches immediately so the next PC
        // shows up on the cycle after the stall drops. If debug took the
        // port instead, that slot becomes a bubble.
        if ((state_q != S_IDLE) && !stall_i && !redirect_i) begin
            fetch_en = !gnt;
            bubble   = gnt;
        end
    end

    assign fault = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= MEM_BYTES);

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pco_d    = pco_q;
        pcp4_d   = pcp4_q;
        err_d    = err_q;
        dvalid_d = gnt;
        ddata_d  = gnt ? mem_instr_i : ddata_q;

        if (dbg_req_i && !gnt) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                : starve_q + 1'b1;
        end else begin
            starve_d = '0;
        end

        unique case (1'b1)
            redirect_i: begin
                pc_d    = redirect_pc_i;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end
            fetch_en: begin
                instr_d = fault ? 32'h0 : mem_instr_i;
                valid_d = 1'b1;
                pco_d   = pc_q;
                pcp4_d  = pc_q + 32'd4;
                pc_d    = pc_q + 32'd4;
                err_d   = err_q | fault;
            end
            bubble: begin
                valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            pco_q    <= 32'h0;
            pcp4_q   <= 32'd4;
            err_q    <= 1'b0;
            dvalid_q <= 1'b0;
            ddata_q  <= 32'h0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pco_q    <= pco_d;
            pcp4_q   <= pcp4_d;
            err_q    <= err_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            starve_q <= starve_d;
        end
    end

    assign mem_addr_o    = gnt ? dbg_addr_i : pc_q;
    assign dbg_gnt_o     = gnt;
    assign dbg_valid_o   = dvalid_q;
    assign dbg_data_o    = ddata_q;
    assign pc_o          = pco_q;
    assign pc_plus4_o    = pcp4_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign addr_err_o    = err_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Testbench for imem_fetch_arbiter: directed vector table for the
// documented scenarios, then random traffic against a behavioural model.
module tb_imem_fetch_arbiter;

    localparam int MAXS  = 4;
    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        rst, stall, redir, req;
    logic [31:0] rpc, daddr;
    logic [31:0] mem_addr, mem_instr;
    logic        dbg_gnt, dbg_valid, instr_valid, addr_err;
    logic [31:0] dbg_data, pc, pc_plus4, instr;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(
        .RESET_PC(32'h0),
        .MEM_WORDS(WORDS),
        .DBG_STARVE_MAX(MAXS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mem_addr_o(mem_addr),
        .mem_instr_i(mem_instr),
        .stall_i(stall),
        .redirect_i(redir),
        .redirect_pc_i(rpc),
        .dbg_req_i(req),
        .dbg_addr_i(daddr),
        .dbg_gnt_o(dbg_gnt),
        .dbg_valid_o(dbg_valid),
        .dbg_data_o(dbg_data),
        .pc_o(pc),
        .pc_plus4_o(pc_plus4),
        .instr_o(instr),
        .instr_valid_o(instr_valid),
        .addr_err_o(addr_err)
    );

    function automatic logic [31:0] iw(input int unsigned i);
        return 32'h1000_0000 + i * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a / 4 < WORDS) return iw(a / 4);
        return 32'hBAD0_0000 ^ a;
    endfunction

    assign mem_instr = mem_rd(mem_addr);

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: the port is free for debug when the pipeline
    // did no useful fetch last cycle (just out of reset, or stalled).
    logic [31:0] m_pc, m_instr, m_pco, m_dd;
    logic        m_valid, m_err, m_dv, m_gnt;
    bit          m_idle, m_hold;
    int          m_starve;
    logic        s_gnt;

    task automatic model_step();
        logic [31:0] data;
        bit          bad;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pco = 0; m_dd = 0;
            m_valid = 0; m_err = 0; m_dv = 0;
            m_idle = 1; m_hold = 0; m_starve = 0;
            return;
        end
        data = mem_rd(m_gnt ? daddr : m_pc);
        m_dv = m_gnt;
        if (m_gnt) m_dd = data;
        if (req && !m_gnt) m_starve = (m_starve < MAXS) ? m_starve + 1 : MAXS;
        else m_starve = 0;
        if (redir) begin
            m_pc = rpc; m_valid = 0; m_err = 0;
        end else if (stall || m_idle) begin
        end else if (m_gnt) begin
            m_valid = 0;
        end else begin
            bad = (m_pc % 4 != 0) || (m_pc >= WORDS * 4);
            m_pco = m_pc;
            m_instr = bad ? 32'h0 : data;
            m_valid = 1;
            if (bad) m_err = 1;
            m_pc = m_pc + 4;
        end
        m_hold = !m_idle && stall && !redir;
        m_idle = 0;
    endtask

    task automatic run_cycle(input logic r, s, d, input logic [31:0] rp,
                             input logic q, input logic [31:0] da);
        rst = r; stall = s; redir = d; rpc = rp; req = q; daddr = da;
        #2;
        m_gnt = q && (m_idle || m_hold || d || m_starve == MAXS);
        s_gnt = dbg_gnt;
        chk("dbg_gnt", {31'h0, dbg_gnt}, {31'h0, m_gnt});
        chk("mem_addr", mem_addr, m_gnt ? da : m_pc);
        model_step();
        @(posedge clk);
        #1;
        chk("instr", instr, m_instr);
        chk("valid", {31'h0, instr_valid}, {31'h0, m_valid});
        chk("pc", pc, m_pco);
        chk("pc_plus4", pc_plus4, m_pco + 32'd4);
        chk("addr_err", {31'h0, addr_err}, {31'h0, m_err});
        chk("dbg_valid", {31'h0, dbg_valid}, {31'h0, m_dv});
        chk("dbg_data", dbg_data, m_dd);
    endtask

    typedef struct {
        logic        r, s, d;
        logic [31:0] rp;
        logic        q;
        logic [31:0] da;
        logic        g, v;
        logic [31:0] pc, ins;
        logic        e, dv;
        logic [31:0] dd;
    } vec_t;

    function automatic vec_t mkv(
        input logic r, s, d, input logic [31:0] rp,
        input logic q, input logic [31:0] da,
        input logic g, v, input logic [31:0] p, ins,
        input logic e, dv, input logic [31:0] dd);
        vec_t t;
        t.r = r; t.s = s; t.d = d; t.rp = rp; t.q = q; t.da = da;
        t.g = g; t.v = v; t.pc = p; t.ins = ins;
        t.e = e; t.dv = dv; t.dd = dd;
        return t;
    endfunction

    vec_t tbl [0:28];

    initial begin
        logic [31:0] d7;
        d7 = iw(7);
        tbl[0]  = mkv(1,0,0,0,0,0,       0,0,32'h00,0,0,0,0);
        tbl[1]  = mkv(0,0,0,0,0,0,       0,0,32'h00,0,0,0,0);
        tbl[2]  = mkv(0,0,0,0,0,0,       0,1,32'h00,iw(0),0,0,0);
        tbl[3]  = mkv(0,0,0,0,0,0,       0,1,32'h04,iw(1),0,0,0);
        tbl[4]  = mkv(0,0,0,0,0,0,       0,1,32'h08,iw(2),0,0,0);
        tbl[5]  = mkv(0,1,0,0,0,0,       0,1,32'h08,iw(2),0,0,0);
        tbl[6]  = mkv(0,1,0,0,0,0,       0,1,32'h08,iw(2),0,0,0);
        tbl[7]  = mkv(0,1,0,0,0,0,       0,1,32'h08,iw(2),0,0,0);
        tbl[8]  = mkv(0,0,0,0,0,0,       0,1,32'h0C,iw(3),0,0,0);
        tbl[9]  = mkv(0,0,0,0,0,0,       0,1,32'h10,iw(4),0,0,0);
        tbl[10] = mkv(0,1,1,32'h40,0,0,  0,0,32'h10,iw(4),0,0,0);
        tbl[11] = mkv(0,0,0,0,0,0,       0,1,32'h40,iw(16),0,0,0);
        tbl[12] = mkv(0,0,0,0,1,32'h1C,  0,1,32'h44,iw(17),0,0,0);
        tbl[13] = mkv(0,0,0,0,1,32'h1C,  0,1,32'h48,iw(18),0,0,0);
        tbl[14] = mkv(0,0,0,0,1,32'h1C,  0,1,32'h4C,iw(19),0,0,0);
        tbl[15] = mkv(0,0,0,0,1,32'h1C,  0,1,32'h50,iw(20),0,0,0);
        tbl[16] = mkv(0,0,0,0,1,32'h1C,  1,0,32'h50,iw(20),0,1,d7);
        tbl[17] = mkv(0,0,0,0,0,0,       0,1,32'h54,iw(21),0,0,d7);
        tbl[18] = mkv(0,0,1,32'h82,0,0,  0,0,32'h54,iw(21),0,0,d7);
        tbl[19] = mkv(0,0,0,0,0,0,       0,1,32'h82,0,1,0,d7);
        tbl[20] = mkv(0,0,0,0,0,0,       0,1,32'h86,0,1,0,d7);
        tbl[21] = mkv(0,0,1,32'h00,0,0,  0,0,32'h86,0,0,0,d7);
        tbl[22] = mkv(0,0,0,0,0,0,       0,1,32'h00,iw(0),0,0,d7);
        tbl[23] = mkv(0,0,1,32'h7C,0,0,  0,0,32'h00,iw(0),0,0,d7);
        tbl[24] = mkv(0,0,0,0,0,0,       0,1,32'h7C,iw(31),0,0,d7);
        tbl[25] = mkv(0,1,0,0,0,0,       0,1,32'h7C,iw(31),0,0,d7);
        tbl[26] = mkv(1,1,0,0,1,32'h10,  1,0,32'h00,0,0,0,0);
        tbl[27] = mkv(0,0,0,0,0,0,       0,0,32'h00,0,0,0,0);
        tbl[28] = mkv(0,0,0,0,0,0,       0,1,32'h00,iw(0),0,0,0);

        rst = 1; stall = 0; redir = 0; rpc = 0; req = 0; daddr = 0;
        @(posedge clk);
        #1;
        model_step();

        for (int i = 0; i <= 28; i++) begin
            run_cycle(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].rp,
                      tbl[i].q, tbl[i].da);
            chk($sformatf("t%0d_gnt", i), {31'h0, s_gnt}, {31'h0, tbl[i].g});
            chk($sformatf("t%0d_valid", i), {31'h0, instr_valid},
                {31'h0, tbl[i].v});
            chk($sformatf("t%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("t%0d_pc4", i), pc_plus4, tbl[i].pc + 32'd4);
            chk($sformatf("t%0d_instr", i), instr, tbl[i].ins);
            chk($sformatf("t%0d_err", i), {31'h0, addr_err},
                {31'h0, tbl[i].e});
            chk($sformatf("t%0d_dv", i), {31'h0, dbg_valid},
                {31'h0, tbl[i].dv});
            chk($sformatf("t%0d_dd", i), dbg_data, tbl[i].dd);
        end

        for (int n = 0; n < 3000; n++) begin
            logic        r, s, d, q;
            logic [31:0] rp, da;
            int unsigned sel;
            r = ($urandom % 100) == 0;
            s = ($urandom % 4) == 0;
            d = ($urandom % 8) == 0;
            sel = $urandom % 10;
            if (sel < 7)       rp = ($urandom % WORDS) * 4;
            else if (sel == 7) rp = ($urandom % WORDS) * 4 + 1 + $urandom % 3;
            else if (sel == 8) rp = 32'h80 + ($urandom % 16) * 4;
            else               rp = 32'hFFFF_FFF8;
            if (req && !m_gnt) begin
                q = 1'b1;
                da = daddr;
            end else begin
                q = ($urandom % 3) == 0;
                da = $urandom % 256;
            end
            run_cycle(r, s, d, rp, q, da);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
Fetch-stage controller that owns the PC and sequences the word-addressed, combinational-read instruction memory (byte address, word index = addr/4).
- Each cycle it grants the single memory read port to either the pipeline fetch path or a debug/trace read requester.
- It registers the fetched word into the IF/ID outputs and handles stall, branch redirect and address faults.
- It sits between the PC logic / IF-ID register and the instruction memory in the pipelined CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_WORDS, 32, instruction memory depth in words; valid byte range is 0 to MEM_WORDS*4-1.
DBG_STARVE_MAX, 4, consecutive cycles a pending debug request may be denied before it is force-granted.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
mem_addr_o  output  32  byte address to the instruction memory (combinational mux).
mem_instr_i  input  32  instruction word from memory, valid in the same cycle as mem_addr_o.
stall_i  input  1  hazard stall; holds the PC and the IF/ID outputs.
redirect_i  input  1  branch/jump taken; load redirect_pc_i.
redirect_pc_i  input  32  redirect target byte address.
dbg_req_i  input  1  debug read request; held high until granted.
dbg_addr_i  input  32  debug read byte address.
dbg_gnt_o  output  1  port granted to debug this cycle (combinational).
dbg_valid_o  output  1  one-cycle pulse: dbg_data_o is valid.
dbg_data_o  output  32  registered debug read data.
pc_o  output  32  PC of instr_o.
pc_plus4_o  output  32  pc_o + 4, mod 2^32.
instr_o  output  32  registered instruction to IF/ID.
instr_valid_o  output  1  instr_o is a real instruction; 0 means bubble.
addr_err_o  output  1  sticky flag: fetch from a misaligned or out-of-range PC.

Behaviour:
- Reset (synchronous; wins over every other input and aborts any in-progress grant):
  - pc_q = RESET_PC; state = IDLE.
  - instr_o = 0, instr_valid_o = 0, pc_o = 0, pc_plus4_o = 4.
  - dbg_valid_o = 0, dbg_data_o = 0, addr_err_o = 0, starve counter = 0.
- FSM states:
  - IDLE: one cycle after reset. No fetch; debug may be granted. Next state FETCH.
  - FETCH: normal fetch operation.
  - HOLD: entered when stall_i=1 and redirect_i=0.
  - Exit HOLD to FETCH when stall_i=0 or redirect_i=1.
- Port grant, evaluated every cycle:
  - dbg_gnt_o=1 if dbg_req_i=1 and any of: state is IDLE or HOLD; redirect_i=1; or starve counter equals DBG_STARVE_MAX.
  - Otherwise fetch owns the port.
  - mem_addr_o = dbg_gnt_o ? dbg_addr_i : pc_q.
- Starve counter:
  - Increments each cycle dbg_req_i=1 and dbg_gnt_o=0, saturating at DBG_STARVE_MAX.
  - Clears on grant or when dbg_req_i=0.
- Fetch cycle (fetch owns the port, FETCH state, stall_i=0, redirect_i=0):
  - instr_o <= mem_instr_i, instr_valid_o <= 1.
  - pc_o <= pc_q, pc_plus4_o <= pc_q+4.
  - pc_q <= pc_q+4, wrapping mod 2^32.
  - Latency from PC to instr_o is 1 cycle.
- Forced debug grant in FETCH:
  - instr_valid_o <= 0 (bubble); pc_q is unchanged.
  - instr_o and pc_o hold their previous values.
- Stall (stall_i=1, redirect_i=0): pc_q, instr_o, instr_valid_o, pc_o and pc_plus4_o all hold.
- Redirect (priority over stall):
  - pc_q <= redirect_pc_i; instr_valid_o <= 0 (flush).
  - The first instruction from the target appears 2 cycles after redirect_i.
  - A debug grant in the same cycle completes normally.
- Debug read:
  - On a grant cycle, dbg_data_o <= mem_instr_i.
  - dbg_valid_o pulses high for exactly the next cycle.
  - Back-to-back grants produce back-to-back valid pulses.
- Address fault:
  - A fetch cycle with pc_q[1:0]!=0 or pc_q >= MEM_WORDS*4 loads instr_o <= 0 (NOP) with instr_valid_o <= 1, and sets addr_err_o.
  - addr_err_o is cleared only by redirect_i or reset.
  - Debug reads are not range-checked.

Test Plan:
- Reset then free-run, no stall: instr_valid_o first high 2 cycles after rst_i falls; pc_o sequence 0,4,8,…; instr_o equals Instr_Mem[pc_o/4]; pc_plus4_o = pc_o+4.
- stall_i high for 3 cycles at pc_o=8: pc_o, instr_o and instr_valid_o hold for 3 cycles; pc_o=12 appears on the cycle after stall_i falls.
- redirect_i with redirect_pc_i=0x40 while stall_i=1: next cycle instr_valid_o=0; following cycle pc_o=0x40, instr_o=Instr_Mem[16], addr_err_o=0.
- dbg_req_i=1, dbg_addr_i=0x1C held during free-run with DBG_STARVE_MAX=4: dbg_gnt_o high on the 5th cycle; one bubble on instr_o; pc sequence continues without skip; dbg_valid_o=1 next cycle with dbg_data_o=Instr_Mem[7].
- redirect_pc_i=0x82: addr_err_o=1 and instr_o=0 on that fetch; addr_err_o stays 1 until redirect to 0x00 clears it.
- rst_i asserted during a debug grant with PC=0x7C: all outputs return to reset values next cycle; dbg_valid_o stays 0; the fetch restarts at RESET_PC.
